// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU/MEM on the integer port
// and FPU/MEM on the FP port, with results registered one cycle after acceptance.
module wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic             mem_fp,
    input  logic [AW-1:0]    mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_ready,
    input  logic             fpu_valid,
    input  logic [AW-1:0]    fpu_rd,
    input  logic [WIDTH-1:0] fpu_data,
    output logic             fpu_ready,
    output logic             regWr,
    output logic [AW-1:0]    rw,
    output logic [WIDTH-1:0] busW,
    output logic             fregWr,
    output logic [AW-1:0]    frw,
    output logic [WIDTH-1:0] fbusW
);

    logic             int_last_q, int_last_d;
    logic             fp_last_q, fp_last_d;
    logic             regWr_q, regWr_d;
    logic [AW-1:0]    rw_q, rw_d;
    logic [WIDTH-1:0] busW_q, busW_d;
    logic             fregWr_q, fregWr_d;
    logic [AW-1:0]    frw_q, frw_d;
    logic [WIDTH-1:0] fbusW_q, fbusW_d;

    logic open;
    logic int_mem_req, fp_mem_req;
    logic alu_gnt, mem_int_gnt, fpu_gnt, mem_fp_gnt;

    // Grants: a sole requester wins; on conflict the side not granted last wins.
    always_comb begin
        open        = ~reset & ~stall;
        int_mem_req = mem_valid & ~mem_fp;
        fp_mem_req  = mem_valid & mem_fp;

        alu_gnt     = open & alu_valid   & (~int_mem_req | ~int_last_q);
        mem_int_gnt = open & int_mem_req & (~alu_valid   |  int_last_q);
        fpu_gnt     = open & fpu_valid   & (~fp_mem_req  | ~fp_last_q);
        mem_fp_gnt  = open & fp_mem_req  & (~fpu_valid   |  fp_last_q);

        int_last_d = int_last_q;
        if (alu_gnt)     int_last_d = 1'b1;
        if (mem_int_gnt) int_last_d = 1'b0;
        fp_last_d = fp_last_q;
        if (fpu_gnt)     fp_last_d = 1'b1;
        if (mem_fp_gnt)  fp_last_d = 1'b0;

        // r0 is hardwired: accept the transfer but suppress the write enable.
        regWr_d = 1'b0;
        rw_d    = rw_q;
        busW_d  = busW_q;
        if (alu_gnt) begin
            regWr_d = (alu_rd != '0);
            rw_d    = alu_rd;
            busW_d  = alu_data;
        end else if (mem_int_gnt) begin
            regWr_d = (mem_rd != '0);
            rw_d    = mem_rd;
            busW_d  = mem_data;
        end

        fregWr_d = 1'b0;
        frw_d    = frw_q;
        fbusW_d  = fbusW_q;
        if (fpu_gnt) begin
            fregWr_d = 1'b1;
            frw_d    = fpu_rd;
            fbusW_d  = fpu_data;
        end else if (mem_fp_gnt) begin
            fregWr_d = 1'b1;
            frw_d    = mem_rd;
            fbusW_d  = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_last_q <= 1'b1;
            fp_last_q  <= 1'b1;
            regWr_q    <= 1'b0;
            rw_q       <= '0;
            busW_q     <= '0;
            fregWr_q   <= 1'b0;
            frw_q      <= '0;
            fbusW_q    <= '0;
        end else begin
            int_last_q <= int_last_d;
            fp_last_q  <= fp_last_d;
            regWr_q    <= regWr_d;
            rw_q       <= rw_d;
            busW_q     <= busW_d;
            fregWr_q   <= fregWr_d;
            frw_q      <= frw_d;
            fbusW_q    <= fbusW_d;
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_int_gnt | mem_fp_gnt;
    assign fpu_ready = fpu_gnt;
    assign regWr     = regWr_q;
    assign rw        = rw_q;
    assign busW      = busW_q;
    assign fregWr    = fregWr_q;
    assign frw       = frw_q;
    assign fbusW     = fbusW_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, contention, parallel ports, r0, stall, mid-handshake reset.
module tb_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset, stall;
    logic             alu_valid, mem_valid, mem_fp, fpu_valid;
    logic [AW-1:0]    alu_rd, mem_rd, fpu_rd;
    logic [WIDTH-1:0] alu_data, mem_data, fpu_data;
    logic             alu_ready, mem_ready, fpu_ready;
    logic             regWr, fregWr;
    logic [AW-1:0]    rw, frw;
    logic [WIDTH-1:0] busW, fbusW;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_fp(mem_fp), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
        .regWr(regWr), .rw(rw), .busW(busW),
        .fregWr(fregWr), .frw(frw), .fbusW(fbusW)
    );

    task automatic idle_inputs();
        stall = 0; alu_valid = 0; mem_valid = 0; fpu_valid = 0; mem_fp = 0;
        alu_rd = '0; mem_rd = '0; fpu_rd = '0;
        alu_data = '0; mem_data = '0; fpu_data = '0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; alu_valid = 1; mem_valid = 1; fpu_valid = 1;
        alu_rd = 5'd3; alu_data = 32'h11; mem_rd = 5'd4; mem_data = 32'h22; fpu_rd = 5'd1;
        #1;
        nvec++;
        if ({alu_ready, mem_ready, fpu_ready} !== 3'b000) begin
            nerr++; $display("FAIL reset_ready: got %b expected 000", {alu_ready, mem_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({regWr, fregWr} !== 2'b00) begin
            nerr++; $display("FAIL reset_we: got %b expected 00", {regWr, fregWr});
        end
        nvec++;
        if ({rw, frw, busW, fbusW} !== '0) begin
            nerr++; $display("FAIL reset_bus: rw=%h frw=%h busW=%h fbusW=%h expected all 0", rw, frw, busW, fbusW);
        end
        step();
        nvec++;
        if ({alu_ready, mem_ready, fpu_ready} !== 3'b000) begin
            nerr++; $display("FAIL reset_hold_ready: got %b expected 000", {alu_ready, mem_ready, fpu_ready});
        end
        reset = 0; fpu_valid = 0;
        #1;
        nvec++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            nerr++; $display("FAIL reset_first_conflict: alu,mem got %b expected 01", {alu_ready, mem_ready});
        end
        step();
        nvec++;
        if ({regWr, rw, busW} !== {1'b1, 5'd4, 32'h22}) begin
            nerr++; $display("FAIL reset_first_write: regWr=%b rw=%0d busW=%h expected 1 4 00000022", regWr, rw, busW);
        end
        idle_inputs();
    endtask

    task automatic test_int_contention();
        apply_reset();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
        mem_valid = 1; mem_fp = 0; mem_rd = 5'd4; mem_data = 32'h22;
        for (int i = 0; i < 8; i++) begin
            logic mem_turn;
            mem_turn = (i % 2 == 0);
            #1;
            nvec++;
            if ({alu_ready, mem_ready} !== {~mem_turn, mem_turn}) begin
                nerr++; $display("FAIL contention_grant[%0d]: alu,mem got %b expected %b",
                                 i, {alu_ready, mem_ready}, {~mem_turn, mem_turn});
            end
            step();
            nvec++;
            if ({regWr, rw, busW} !== (mem_turn ? {1'b1, 5'd4, 32'h22} : {1'b1, 5'd3, 32'h11})) begin
                nerr++; $display("FAIL contention_write[%0d]: regWr=%b rw=%0d busW=%h expected rw=%0d",
                                 i, regWr, rw, busW, mem_turn ? 4 : 3);
            end
        end
        idle_inputs();
    endtask

    task automatic test_parallel_ports();
        apply_reset();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hA;
        fpu_valid = 1; fpu_rd = 5'd2; fpu_data = 32'hB;
        #1;
        nvec++;
        if ({alu_ready, mem_ready, fpu_ready} !== 3'b101) begin
            nerr++; $display("FAIL parallel_ready: got %b expected 101", {alu_ready, mem_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({regWr, rw, busW, fregWr, frw, fbusW} !== {1'b1, 5'd5, 32'hA, 1'b1, 5'd2, 32'hB}) begin
            nerr++; $display("FAIL parallel_write: regWr=%b rw=%0d busW=%h fregWr=%b frw=%0d fbusW=%h expected 1 5 a 1 2 b",
                             regWr, rw, busW, fregWr, frw, fbusW);
        end
        idle_inputs();
        step();
        nvec++;
        if ({regWr, rw, busW, fregWr, frw, fbusW} !== {1'b0, 5'd5, 32'hA, 1'b0, 5'd2, 32'hB}) begin
            nerr++; $display("FAIL parallel_idle_hold: regWr=%b rw=%0d busW=%h fregWr=%b frw=%0d fbusW=%h expected 0 5 a 0 2 b",
                             regWr, rw, busW, fregWr, frw, fbusW);
        end
        // MEM to the FP port must not block the ALU on the integer port.
        mem_valid = 1; mem_fp = 1; mem_rd = 5'd8; mem_data = 32'h55;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h66;
        #1;
        nvec++;
        if ({alu_ready, mem_ready, fpu_ready} !== 3'b110) begin
            nerr++; $display("FAIL indep_ready: got %b expected 110", {alu_ready, mem_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({regWr, rw, busW, fregWr, frw, fbusW} !== {1'b1, 5'd3, 32'h66, 1'b1, 5'd8, 32'h55}) begin
            nerr++; $display("FAIL indep_write: regWr=%b rw=%0d busW=%h fregWr=%b frw=%0d fbusW=%h expected 1 3 66 1 8 55",
                             regWr, rw, busW, fregWr, frw, fbusW);
        end
        idle_inputs();
    endtask

    task automatic test_r0_write();
        apply_reset();
        mem_valid = 1; mem_fp = 0; mem_rd = 5'd9; mem_data = 32'h1;
        step();
        idle_inputs();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        nvec++;
        if (alu_ready !== 1'b1) begin
            nerr++; $display("FAIL r0_ready: got %b expected 1", alu_ready);
        end
        step();
        nvec++;
        if (regWr !== 1'b0) begin
            nerr++; $display("FAIL r0_no_write: regWr got %b expected 0", regWr);
        end
        alu_rd = 5'd6; alu_data = 32'h60;
        mem_valid = 1; mem_fp = 0; mem_rd = 5'd7; mem_data = 32'h70;
        #1;
        nvec++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            nerr++; $display("FAIL r0_pointer: alu,mem got %b expected 01", {alu_ready, mem_ready});
        end
        step();
        nvec++;
        if ({regWr, rw, busW} !== {1'b1, 5'd7, 32'h70}) begin
            nerr++; $display("FAIL r0_after_write: regWr=%b rw=%0d busW=%h expected 1 7 70", regWr, rw, busW);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        stall = 1;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
        fpu_valid = 1; fpu_rd = 5'd9; fpu_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++;
            if ({alu_ready, mem_ready, fpu_ready} !== 3'b000) begin
                nerr++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, {alu_ready, mem_ready, fpu_ready});
            end
            step();
            nvec++;
            if ({regWr, fregWr} !== 2'b00) begin
                nerr++; $display("FAIL stall_we[%0d]: got %b expected 00", i, {regWr, fregWr});
            end
        end
        stall = 0;
        #1;
        nvec++;
        if ({alu_ready, fpu_ready} !== 2'b11) begin
            nerr++; $display("FAIL stall_release_ready: got %b expected 11", {alu_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({regWr, rw, busW, fregWr, frw, fbusW} !== {1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99}) begin
            nerr++; $display("FAIL stall_release_write: regWr=%b rw=%0d busW=%h fregWr=%b frw=%0d fbusW=%h expected 1 7 77 1 9 99",
                             regWr, rw, busW, fregWr, frw, fbusW);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        mem_valid = 1; mem_fp = 1; mem_rd = 5'd1; mem_data = 32'h33;
        fpu_valid = 1; fpu_rd = 5'd6; fpu_data = 32'h44;
        #1;
        nvec++;
        if ({alu_ready, mem_ready, fpu_ready} !== 3'b010) begin
            nerr++; $display("FAIL midrst_first: got %b expected 010", {alu_ready, mem_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({regWr, fregWr, frw, fbusW} !== {1'b0, 1'b1, 5'd1, 32'h33}) begin
            nerr++; $display("FAIL midrst_mem_write: regWr=%b fregWr=%b frw=%0d fbusW=%h expected 0 1 1 33",
                             regWr, fregWr, frw, fbusW);
        end
        // FPU is now owed the port; a reset must forget that.
        reset = 1;
        #1;
        nvec++;
        if ({alu_ready, mem_ready, fpu_ready} !== 3'b000) begin
            nerr++; $display("FAIL midrst_ready: got %b expected 000", {alu_ready, mem_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({fregWr, frw, fbusW} !== '0) begin
            nerr++; $display("FAIL midrst_outputs: fregWr=%b frw=%0d fbusW=%h expected 0 0 0", fregWr, frw, fbusW);
        end
        reset = 0;
        #1;
        nvec++;
        if ({mem_ready, fpu_ready} !== 2'b10) begin
            nerr++; $display("FAIL midrst_pointer: mem,fpu got %b expected 10", {mem_ready, fpu_ready});
        end
        step();
        nvec++;
        if ({fregWr, frw, fbusW} !== {1'b1, 5'd1, 32'h33}) begin
            nerr++; $display("FAIL midrst_rewrite: fregWr=%b frw=%0d fbusW=%h expected 1 1 33", fregWr, frw, fbusW);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_int_contention();
        test_parallel_ports();
        test_r0_write();
        test_stall();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
